pipe_mem_stage: RTL and testbench
=================================

Name: pipe_mem_stage

Overview:
- Memory-access stage of the 5-stage pipeline.
- Consumes the EX/MEM register outputs (mwreg, mm2reg, mwmem, malu, mb, mrn) and drives a req/ack data-memory port.
- Stalls the front of the pipeline while an access is outstanding and contains the MEM/WB pipeline register feeding write-back.
- Adds a wait-state timeout and a misalignment check. Either fault squashes the instruction.

Parameters:
- MAX_WAIT, 15: maximum BUSY cycles without dm_ack before abort. Range 1..255.
- CW, 8: width of the wait counter. Must satisfy 2^CW > MAX_WAIT.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clr  in  1  synchronous active-high reset.
- mwreg  in  1  EX/MEM register-write enable.
- mm2reg  in  1  EX/MEM load (memory-to-register) flag.
- mwmem  in  1  EX/MEM store flag.
- malu  in  32  EX/MEM ALU result; byte address for loads/stores.
- mb  in  32  EX/MEM store data.
- mrn  in  5  EX/MEM destination register number.
- dm_req  out  1  data-memory request.
- dm_we  out  1  data-memory write enable (store).
- dm_addr  out  32  data-memory byte address.
- dm_wdata  out  32  data-memory write data.
- dm_ack  in  1  data-memory completion; rdata valid same cycle for loads.
- dm_rdata  in  32  data-memory read data.
- mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle.
- mem_err  out  1  one-cycle fault pulse (misaligned or timeout).
- wwreg  out  1  MEM/WB register-write enable.
- wm2reg  out  1  MEM/WB load flag.
- wmo  out  32  MEM/WB memory data.
- walu  out  32  MEM/WB ALU result.
- wrn  out  5  MEM/WB destination register number.

Behaviour:
- Reset:
  - clr=1 at a rising edge forces state=IDLE, wait counter=0, and wwreg, wm2reg, wmo, walu, wrn, mem_err all 0.
  - While clr=1, dm_req=0 and mem_stall=0 combinationally, regardless of inputs.
  - A reset during BUSY abandons the access. No MEM/WB update and no mem_err.
- Definitions:
  - access = mm2reg | mwmem
  - mis = access & (malu[1:0] != 0)
  - dm_addr = malu, dm_wdata = mb, dm_we = mwmem (combinational). These are don't-care when dm_req=0.
- State IDLE:
  - access & !mis:
    - dm_req=1 combinationally.
    - If dm_ack=1 in the same cycle (zero-wait): mem_stall=0, and MEM/WB latches the instruction at the edge. wmo = dm_rdata if mm2reg, else 0.
    - If dm_ack=0: mem_stall=1, MEM/WB loads a bubble, counter←1, next=BUSY.
  - mis:
    - dm_req=0, mem_stall=0.
    - mem_err=1 next cycle for one cycle.
    - MEM/WB loads a bubble. The instruction is squashed.
  - !access:
    - dm_req=0, mem_stall=0. dm_ack is ignored.
    - MEM/WB latches wwreg←mwreg, wm2reg←0, walu←malu, wrn←mrn, wmo←0.
- State BUSY:
  - dm_req=1. EX/MEM inputs are stable because upstream is frozen.
  - dm_ack=1: mem_stall=0, MEM/WB latches the instruction (wmo=dm_rdata for loads), counter←0, next=IDLE.
  - dm_ack=0 and counter<MAX_WAIT: mem_stall=1, MEM/WB bubble, counter+1.
  - dm_ack=0 and counter==MAX_WAIT (timeout):
    - dm_req=1 this cycle, mem_stall=0.
    - MEM/WB bubble (instruction squashed), mem_err=1 next cycle, counter←0, next=IDLE.
    - dm_req is low in the following cycle unless the next instruction accesses memory.
- Bubble definition: wwreg=0, wm2reg=0, wmo=0, walu=0, wrn=0.
- Ordering: one access outstanding at most. The next instruction's request cannot start before the current one is acked or aborted.
- mem_err is registered: high exactly one cycle after the fault cycle, otherwise 0.

Test Plan:
- Reset: assert clr with mm2reg=1, malu=0x10 → dm_req=0, mem_stall=0. After the edge all W outputs=0, state IDLE.
- ALU pass-through: mwreg=1, mm2reg=0, mwmem=0, malu=0x1234, mrn=5 → no dm_req. Next cycle wwreg=1, walu=0x1234, wrn=5, wmo=0.
- Zero-wait load: mm2reg=1, mwreg=1, malu=0x40, dm_ack=1, dm_rdata=0xDEADBEEF in the same cycle → mem_stall=0. Next cycle wm2reg=1, wmo=0xDEADBEEF, wrn per mrn.
- 3-wait store: mwmem=1, malu=0x80, mb=0xCAFE, ack on the 4th request cycle → dm_req/dm_we high 4 cycles, dm_wdata=0xCAFE, mem_stall high 3 cycles, MEM/WB bubbles for 3 cycles, then store latched with wwreg=mwreg.
- Misaligned load: mm2reg=1, malu=0x42 → dm_req never high, no stall. Next cycle mem_err=1 for one cycle, wwreg=0.
- Timeout: MAX_WAIT=4, load with dm_ack held 0 → dm_req high 5 cycles, mem_stall high 4 cycles. Then mem_err pulse, wwreg=0, back to IDLE. Repeat with clr asserted in the 2nd BUSY cycle → dm_req=0 immediately, no mem_err.

Source files
------------

// File: rtl/pipe_mem_stage.sv
// rtl/pipe_mem_stage.sv - MEM stage: req/ack data-memory port, stall, fault squash, MEM/WB register
module pipe_mem_stage #(
  parameter int MAX_WAIT = 15,
  parameter int CW       = 8
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  input  logic [4:0]  mrn,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        mem_stall,
  output logic        mem_err,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic [4:0]  wrn
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [CW-1:0] MAXW = CW'(MAX_WAIT);

  state_t        state;
  logic [CW-1:0] cnt;

  logic access;
  logic mis;
  logic busy;
  logic timeout;
  logic latch;
  logic fault;

  // Address, data and direction are wired straight through; only dm_req qualifies them.
  assign dm_addr  = malu;
  assign dm_wdata = mb;
  assign dm_we    = mwmem;

  // Classify the instruction in EX/MEM and decide request, stall, commit and fault for this cycle.
  always_comb begin
    access    = mm2reg | mwmem;
    mis       = access & (malu[1:0] != 2'b00);
    busy      = (state == BUSY);
    timeout   = busy & ~dm_ack & (cnt == MAXW);
    dm_req    = ~clr & (busy | (access & ~mis));
    // A timed-out access releases the pipeline in the same cycle it is abandoned.
    mem_stall = ~clr & dm_req & ~dm_ack & ~timeout;
    // Commit when a non-memory op passes, or when a good access is acknowledged.
    latch     = busy ? dm_ack : (~mis & (~access | dm_ack));
    fault     = busy ? timeout : mis;
  end

  // Wait-state FSM, one-cycle fault pulse, and the MEM/WB register (bubble unless committing).
  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      cnt     <= '0;
      mem_err <= 1'b0;
      wwreg   <= 1'b0;
      wm2reg  <= 1'b0;
      wmo     <= 32'h0;
      walu    <= 32'h0;
      wrn     <= 5'h0;
    end else begin
      mem_err <= fault;

      if (latch) begin
        wwreg  <= mwreg;
        wm2reg <= mm2reg;
        wmo    <= mm2reg ? dm_rdata : 32'h0;
        walu   <= malu;
        wrn    <= mrn;
      end else begin
        wwreg  <= 1'b0;
        wm2reg <= 1'b0;
        wmo    <= 32'h0;
        walu   <= 32'h0;
        wrn    <= 5'h0;
      end

      case (state)
        IDLE: begin
          if (access && !mis && !dm_ack) begin
            state <= BUSY;
            cnt   <= CW'(1);
          end
        end
        BUSY: begin
          if (dm_ack || timeout) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_mem_stage.sv
// tb/tb_pipe_mem_stage.sv - self-checking bench for pipe_mem_stage
module tb_pipe_mem_stage;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        clr;
  logic        mwreg, mm2reg, mwmem;
  logic [31:0] malu, mb;
  logic [4:0]  mrn;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        mem_stall, mem_err;
  logic        wwreg, wm2reg;
  logic [31:0] wmo, walu;
  logic [4:0]  wrn;

  int errs = 0;
  int checks = 0;

  pipe_mem_stage #(.MAX_WAIT(MW), .CW(8)) dut (
    .clk(clk), .clr(clr),
    .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
    .malu(malu), .mb(mb), .mrn(mrn),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_stall(mem_stall), .mem_err(mem_err),
    .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo), .walu(walu), .wrn(wrn)
  );

  always #5 clk = ~clk;

  function automatic logic [70:0] wb_vec();
    return {wwreg, wm2reg, wmo, walu, wrn};
  endfunction

  task automatic drive(input logic wr, input logic ld, input logic st, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rn);
    mwreg = wr; mm2reg = ld; mwmem = st; malu = a; mb = d; mrn = rn;
  endtask

  // advance one clock and land 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; dm_ack = 1'b0; dm_rdata = 32'h0;
    drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd3);
    #1;
    checks++; if (dm_req !== 1'b0) begin errs++; $display("FAIL reset_req got=%b exp=0", dm_req); end
    checks++; if (mem_stall !== 1'b0) begin errs++; $display("FAIL reset_stall got=%b exp=0", mem_stall); end
    step();
    step();
    checks++; if (wb_vec() !== 71'h0) begin errs++; $display("FAIL reset_wb got=%h exp=0", wb_vec()); end
    checks++; if (mem_err !== 1'b0) begin errs++; $display("FAIL reset_err got=%b exp=0", mem_err); end
    clr = 1'b0;
  endtask

  task automatic test_alu_pass();
    drive(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5);
    dm_ack = 1'b1;
    #1;
    checks++; if (dm_req !== 1'b0) begin errs++; $display("FAIL alu_req got=%b exp=0", dm_req); end
    checks++; if (mem_stall !== 1'b0) begin errs++; $display("FAIL alu_stall got=%b exp=0", mem_stall); end
    step();
    dm_ack = 1'b0;
    checks++; if (wb_vec() !== {1'b1, 1'b0, 32'h0, 32'h1234, 5'd5}) begin errs++; $display("FAIL alu_wb got=%h", wb_vec()); end
  endtask

  task automatic test_zero_wait_load();
    drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd9);
    dm_ack = 1'b1; dm_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (dm_req !== 1'b1) begin errs++; $display("FAIL zw_req got=%b exp=1", dm_req); end
    checks++; if (mem_stall !== 1'b0) begin errs++; $display("FAIL zw_stall got=%b exp=0", mem_stall); end
    checks++; if (dm_addr !== 32'h40) begin errs++; $display("FAIL zw_addr got=%h exp=40", dm_addr); end
    step();
    dm_ack = 1'b0;
    checks++; if (wb_vec() !== {1'b1, 1'b1, 32'hDEADBEEF, 32'h40, 5'd9}) begin errs++; $display("FAIL zw_wb got=%h", wb_vec()); end
  endtask

  task automatic test_wait_store();
    drive(1'b1, 1'b0, 1'b1, 32'h80, 32'hCAFE, 5'd7);
    for (int k = 0; k < 4; k++) begin
      dm_ack = (k == 3);
      #1;
      checks++; if ({dm_req, dm_we} !== 2'b11) begin errs++; $display("FAIL st_req_we k=%0d got=%b exp=11", k, {dm_req, dm_we}); end
      checks++; if (dm_wdata !== 32'hCAFE) begin errs++; $display("FAIL st_wdata k=%0d got=%h exp=cafe", k, dm_wdata); end
      checks++; if (mem_stall !== (k < 3)) begin errs++; $display("FAIL st_stall k=%0d got=%b exp=%b", k, mem_stall, k < 3); end
      step();
      if (k < 3) begin
        checks++; if (wb_vec() !== 71'h0) begin errs++; $display("FAIL st_bubble k=%0d got=%h exp=0", k, wb_vec()); end
      end else begin
        checks++; if (wb_vec() !== {1'b1, 1'b0, 32'h0, 32'h80, 5'd7}) begin errs++; $display("FAIL st_wb got=%h", wb_vec()); end
      end
    end
    dm_ack = 1'b0;
  endtask

  task automatic test_misaligned();
    drive(1'b1, 1'b1, 1'b0, 32'h42, 32'h0, 5'd4);
    #1;
    checks++; if (dm_req !== 1'b0) begin errs++; $display("FAIL mis_req got=%b exp=0", dm_req); end
    checks++; if (mem_stall !== 1'b0) begin errs++; $display("FAIL mis_stall got=%b exp=0", mem_stall); end
    step();
    checks++; if (mem_err !== 1'b1) begin errs++; $display("FAIL mis_err got=%b exp=1", mem_err); end
    checks++; if (wb_vec() !== 71'h0) begin errs++; $display("FAIL mis_wb got=%h exp=0", wb_vec()); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    checks++; if (mem_err !== 1'b0) begin errs++; $display("FAIL mis_err_clear got=%b exp=0", mem_err); end
  endtask

  task automatic test_timeout();
    drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd2);
    dm_ack = 1'b0;
    for (int k = 0; k <= MW; k++) begin
      #1;
      checks++; if (dm_req !== 1'b1) begin errs++; $display("FAIL to_req k=%0d got=%b exp=1", k, dm_req); end
      checks++; if (mem_stall !== (k < MW)) begin errs++; $display("FAIL to_stall k=%0d got=%b exp=%b", k, mem_stall, k < MW); end
      step();
      checks++; if (mem_err !== (k == MW)) begin errs++; $display("FAIL to_err k=%0d got=%b exp=%b", k, mem_err, k == MW); end
      checks++; if (wwreg !== 1'b0) begin errs++; $display("FAIL to_wwreg k=%0d got=%b exp=0", k, wwreg); end
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    checks++; if (dm_req !== 1'b0) begin errs++; $display("FAIL to_idle_req got=%b exp=0", dm_req); end
    step();
    checks++; if (mem_err !== 1'b0) begin errs++; $display("FAIL to_err_clear got=%b exp=0", mem_err); end
  endtask

  task automatic test_reset_in_busy();
    drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd2);
    dm_ack = 1'b0;
    step();
    step();
    clr = 1'b1;
    #1;
    checks++; if (dm_req !== 1'b0) begin errs++; $display("FAIL rb_req got=%b exp=0", dm_req); end
    checks++; if (mem_stall !== 1'b0) begin errs++; $display("FAIL rb_stall got=%b exp=0", mem_stall); end
    step();
    clr = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    checks++; if (dm_req !== 1'b0) begin errs++; $display("FAIL rb_idle_req got=%b exp=0", dm_req); end
    checks++; if (mem_err !== 1'b0) begin errs++; $display("FAIL rb_err got=%b exp=0", mem_err); end
    step();
    checks++; if (mem_err !== 1'b0) begin errs++; $display("FAIL rb_err2 got=%b exp=0", mem_err); end
    checks++; if (wb_vec() !== 71'h0) begin errs++; $display("FAIL rb_wb got=%h exp=0", wb_vec()); end
  endtask

  // Instruction-level reference: each instruction is a kind plus an ack latency (MW+1 = never acked).
  task automatic test_random();
    int kind, lat;
    logic wr, ld, st;
    logic [31:0] a, d, rd;
    logic [4:0] rn;
    logic [70:0] exp_wb;
    logic exp_err, exp_stall;
    for (int n = 0; n < 80; n++) begin
      kind = int'($urandom_range(0, 3));
      wr = 1'($urandom); rn = 5'($urandom); d = $urandom;
      a = $urandom;
      ld = 1'b0; st = 1'b0;
      if (kind == 1) ld = 1'b1;
      if (kind == 2) st = 1'b1;
      if (kind == 3) begin
        if ($urandom_range(0, 1) == 1) ld = 1'b1; else st = 1'b1;
        if (a[1:0] == 2'b00) a[0] = 1'b1;
      end else begin
        a[1:0] = 2'b00;
      end
      drive(wr, ld, st, a, d, rn);
      if (kind == 0 || kind == 3) begin
        dm_ack = 1'($urandom);
        #1;
        checks++; if ({dm_req, mem_stall} !== 2'b00) begin errs++; $display("FAIL rnd_noreq n=%0d got=%b exp=00", n, {dm_req, mem_stall}); end
        step();
        exp_wb  = (kind == 0) ? {wr, 1'b0, 32'h0, a, rn} : 71'h0;
        exp_err = (kind == 3);
        checks++; if ({mem_err, wb_vec()} !== {exp_err, exp_wb}) begin errs++; $display("FAIL rnd_simple n=%0d got=%b/%h exp=%b/%h", n, mem_err, wb_vec(), exp_err, exp_wb); end
      end else begin
        lat = int'($urandom_range(0, MW + 1));
        for (int k = 0; k <= MW; k++) begin
          dm_ack = (k == lat);
          rd = $urandom;
          dm_rdata = rd;
          exp_stall = !dm_ack && (k < MW);
          #1;
          checks++; if ({dm_req, dm_we, dm_addr, dm_wdata} !== {1'b1, st, a, d}) begin errs++; $display("FAIL rnd_port n=%0d k=%0d got=%b%b %h %h", n, k, dm_req, dm_we, dm_addr, dm_wdata); end
          checks++; if (mem_stall !== exp_stall) begin errs++; $display("FAIL rnd_stall n=%0d k=%0d got=%b exp=%b", n, k, mem_stall, exp_stall); end
          step();
          exp_wb  = (k == lat) ? {wr, ld, (ld ? rd : 32'h0), a, rn} : 71'h0;
          exp_err = (k == MW) && (lat > MW);
          checks++; if ({mem_err, wb_vec()} !== {exp_err, exp_wb}) begin errs++; $display("FAIL rnd_mem n=%0d k=%0d got=%b/%h exp=%b/%h", n, k, mem_err, wb_vec(), exp_err, exp_wb); end
          if (k == lat) break;
        end
      end
      dm_ack = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_alu_pass();
    test_zero_wait_load();
    test_wait_store();
    test_misaligned();
    test_timeout();
    test_reset_in_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
